// File: rtl/mem_access_pkg.sv
// Shared encodings for mem_access_unit: access sizes, FSM states and the alignment check.
// The RMW states exist only when SUBWORD_RMW_EN is defined.
package mem_access_pkg;

    typedef enum logic [1:0] {
        SizeByte = 2'd0,
        SizeHalf = 2'd1,
        SizeWord = 2'd2,
        SizeRsvd = 2'd3
    } size_e;

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StAccess = 3'd1;
    localparam logic [2:0] StResp   = 3'd2;
`ifdef SUBWORD_RMW_EN
    localparam logic [2:0] StRmwRd  = 3'd3;
    localparam logic [2:0] StRmwWr  = 3'd4;
`endif

    // The reserved size is always reported as misaligned.
    function automatic logic is_misaligned(input size_e size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SizeByte: bad = 1'b0;
            SizeHalf: bad = addr_lo[0];
            SizeWord: bad = |addr_lo;
            default:  bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for mem_access_unit: little-endian load extract/extend and
// store byte-merge into a base word.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [31:0] ld_word_i,
    input  logic [1:0]  ld_lane_i,
    input  size_e       ld_size_i,
    input  logic        ld_unsigned_i,
    output logic [31:0] ld_data_o,
    input  logic [31:0] st_base_i,
    input  logic [31:0] st_wdata_i,
    input  logic [1:0]  st_lane_i,
    input  size_e       st_size_i,
    output logic [31:0] st_word_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        ld_byte = ld_word_i[{ld_lane_i, 3'b000} +: 8];
        ld_half = ld_word_i[{ld_lane_i[1], 4'b0000} +: 16];
        case (ld_size_i)
            SizeByte: ld_data_o = {{24{ld_byte[7] & ~ld_unsigned_i}}, ld_byte};
            SizeHalf: ld_data_o = {{16{ld_half[15] & ~ld_unsigned_i}}, ld_half};
            default:  ld_data_o = ld_word_i;
        endcase
    end

    always_comb begin
        st_word_o = st_base_i;
        case (st_size_i)
            SizeByte: st_word_o[{st_lane_i, 3'b000} +: 8]     = st_wdata_i[7:0];
            SizeHalf: st_word_o[{st_lane_i[1], 4'b0000} +: 16] = st_wdata_i[15:0];
            default:  st_word_o = st_wdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer between execute stage and data-memory wrapper.
// Define SUBWORD_RMW_EN to turn sub-word stores into read-modify-write instead of errors.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    input  logic [TAG_W-1:0] req_tag,
    output logic             resp_valid,
    output logic [31:0]      resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic             resp_err,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_data_in,
    output logic             mem_write_enable,
    output logic             mem_read_enable,
    input  logic [31:0]      mem_data_out,
    input  logic             mem_miss
);

    logic [2:0]       state_q, state_d;
    size_e            size_q, size_d;
    logic             uns_q, uns_d;
    logic [1:0]       lane_q, lane_d;
    logic             we_q, we_d;
    logic [TAG_W-1:0] tag_q, tag_d;
`ifdef SUBWORD_RMW_EN
    logic [31:0]      wdata_q, wdata_d;
`endif
    logic             resp_valid_q, resp_valid_d;
    logic [31:0]      resp_data_q, resp_data_d;
    logic [TAG_W-1:0] resp_tag_q, resp_tag_d;
    logic             resp_err_q, resp_err_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic             mem_we_q, mem_we_d;
    logic             mem_re_q, mem_re_d;

    size_e       req_size_e;
    logic        accept;
    logic        req_err;
    logic [31:0] ld_data;
    logic [31:0] st_word;
    logic [31:0] word_store_data;

    assign req_size_e = size_e'(req_size);
    assign req_ready  = (state_q == StIdle) || (state_q == StResp);
    assign accept     = req_valid & req_ready;

`ifdef SUBWORD_RMW_EN
    assign req_err         = is_misaligned(req_size_e, req_addr[1:0]);
    assign word_store_data = req_wdata;
`else
    assign req_err         = is_misaligned(req_size_e, req_addr[1:0]) |
                             (req_we & (req_size_e != SizeWord));
    assign word_store_data = st_word;
`endif

    // Without RMW the merge path only ever sees word stores, so it is fed from the request.
    mem_lane_align u_lane_align (
        .ld_word_i     (mem_data_out),
        .ld_lane_i     (lane_q),
        .ld_size_i     (size_q),
        .ld_unsigned_i (uns_q),
        .ld_data_o     (ld_data),
`ifdef SUBWORD_RMW_EN
        .st_base_i     (mem_data_out),
        .st_wdata_i    (wdata_q),
        .st_lane_i     (lane_q),
        .st_size_i     (size_q),
`else
        .st_base_i     (32'h0),
        .st_wdata_i    (req_wdata),
        .st_lane_i     (req_addr[1:0]),
        .st_size_i     (req_size_e),
`endif
        .st_word_o     (st_word)
    );

    always_comb begin
        state_d      = state_q;
        size_d       = size_q;
        uns_d        = uns_q;
        lane_d       = lane_q;
        we_d         = we_q;
        tag_d        = tag_q;
`ifdef SUBWORD_RMW_EN
        wdata_d      = wdata_q;
`endif
        resp_valid_d = 1'b0;
        resp_data_d  = resp_data_q;
        resp_tag_d   = resp_tag_q;
        resp_err_d   = resp_err_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_we_d     = mem_we_q;
        mem_re_d     = mem_re_q;

        case (state_q)
            StIdle, StResp: begin
                state_d = StIdle;
                if (accept) begin
                    size_d  = req_size_e;
                    uns_d   = req_unsigned;
                    lane_d  = req_addr[1:0];
                    we_d    = req_we;
                    tag_d   = req_tag;
`ifdef SUBWORD_RMW_EN
                    wdata_d = req_wdata;
`endif
                    if (req_err) begin
                        state_d      = StResp;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_data_d  = 32'h0;
                        resp_tag_d   = req_tag;
                    end else begin
                        mem_addr_d = {2'b00, req_addr[31:2]};
                        if (!req_we) begin
                            mem_re_d = 1'b1;
                            state_d  = StAccess;
                        end
`ifdef SUBWORD_RMW_EN
                        else if (req_size_e != SizeWord) begin
                            mem_re_d = 1'b1;
                            state_d  = StRmwRd;
                        end
`endif
                        else begin
                            mem_we_d    = 1'b1;
                            mem_wdata_d = word_store_data;
                            state_d     = StAccess;
                        end
                    end
                end
            end
            StAccess: begin
                if (!mem_miss) begin
                    state_d      = StResp;
                    mem_re_d     = 1'b0;
                    mem_we_d     = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_tag_d   = tag_q;
                    resp_data_d  = we_q ? 32'h0 : ld_data;
                end
            end
`ifdef SUBWORD_RMW_EN
            StRmwRd: begin
                if (!mem_miss) begin
                    state_d     = StRmwWr;
                    mem_re_d    = 1'b0;
                    mem_we_d    = 1'b1;
                    mem_wdata_d = st_word;
                end
            end
            StRmwWr: begin
                if (!mem_miss) begin
                    state_d      = StResp;
                    mem_we_d     = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_tag_d   = tag_q;
                    resp_data_d  = 32'h0;
                end
            end
`endif
            default: begin
                state_d  = StIdle;
                mem_re_d = 1'b0;
                mem_we_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= StIdle;
            size_q       <= SizeByte;
            uns_q        <= 1'b0;
            lane_q       <= 2'b00;
            we_q         <= 1'b0;
            tag_q        <= '0;
`ifdef SUBWORD_RMW_EN
            wdata_q      <= 32'h0;
`endif
            resp_valid_q <= 1'b0;
            resp_data_q  <= 32'h0;
            resp_tag_q   <= '0;
            resp_err_q   <= 1'b0;
            mem_addr_q   <= 32'h0;
            mem_wdata_q  <= 32'h0;
            mem_we_q     <= 1'b0;
            mem_re_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            lane_q       <= lane_d;
            we_q         <= we_d;
            tag_q        <= tag_d;
`ifdef SUBWORD_RMW_EN
            wdata_q      <= wdata_d;
`endif
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_tag_q   <= resp_tag_d;
            resp_err_q   <= resp_err_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= mem_we_d;
            mem_re_q     <= mem_re_d;
        end
    end

    assign resp_valid       = resp_valid_q;
    assign resp_data        = resp_data_q;
    assign resp_tag         = resp_tag_q;
    assign resp_err         = resp_err_q;
    assign mem_addr         = mem_addr_q;
    assign mem_data_in      = mem_wdata_q;
    assign mem_write_enable = mem_we_q;
    assign mem_read_enable  = mem_re_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus randomized requests
// checked against a word-array reference model. Honours SUBWORD_RMW_EN.
module tb_mem_access_unit;

    localparam int TAG_W = 5;
`ifdef SUBWORD_RMW_EN
    localparam bit RMW = 1'b1;
`else
    localparam bit RMW = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rstn;
    logic             req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]       req_size;
    logic [31:0]      req_addr, req_wdata;
    logic [TAG_W-1:0] req_tag;
    logic             resp_valid, resp_err;
    logic [31:0]      resp_data;
    logic [TAG_W-1:0] resp_tag;
    logic [31:0]      mem_addr, mem_data_in, mem_data_out;
    logic             mem_write_enable, mem_read_enable, mem_miss;

    int checks = 0;
    int errors = 0;

    mem_access_unit #(.TAG_W(TAG_W)) dut (
        .clk              (clk),
        .rstn             (rstn),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_we           (req_we),
        .req_size         (req_size),
        .req_unsigned     (req_unsigned),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .req_tag          (req_tag),
        .resp_valid       (resp_valid),
        .resp_data        (resp_data),
        .resp_tag         (resp_tag),
        .resp_err         (resp_err),
        .mem_addr         (mem_addr),
        .mem_data_in      (mem_data_in),
        .mem_write_enable (mem_write_enable),
        .mem_read_enable  (mem_read_enable),
        .mem_data_out     (mem_data_out),
        .mem_miss         (mem_miss)
    );

    always #5 clk = ~clk;

    // Memory wrapper model: tbmem is only written by the stimulus process; DUT writes are logged.
    logic [31:0] tbmem   [16];
    logic [31:0] ref_mem [16];
    int unsigned miss_plan = 0;
    int unsigned en_cycles = 0;
    int unsigned wr_cnt    = 0;
    logic [31:0] wr_addr   = 32'h0;
    logic [31:0] wr_data   = 32'h0;

    assign mem_miss     = (mem_read_enable | mem_write_enable) && (en_cycles < miss_plan);
    assign mem_data_out = (mem_read_enable && !mem_miss) ? tbmem[mem_addr[3:0]] : 32'hA5A5_5A5A;

    always @(posedge clk) begin
        if (mem_read_enable | mem_write_enable)
            en_cycles <= mem_miss ? en_cycles + 1 : 0;
        else
            en_cycles <= 0;
        if (mem_write_enable && !mem_miss) begin
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= mem_addr;
            wr_data <= mem_data_in;
        end
    end

    // Results of the last issue() call.
    int unsigned      r_lat, rd_cyc, wr_cyc, both_cyc, busy_ready;
    logic [31:0]      r_data, first_addr;
    logic             r_err, ready_at_issue;
    logic [TAG_W-1:0] r_tag;
    bit               unstable;

    function automatic bit ref_err(bit we, int unsigned size, int unsigned addr);
        if (size == 3) return 1'b1;
        if (size == 2 && addr % 4 != 0) return 1'b1;
        if (size == 1 && addr % 2 != 0) return 1'b1;
        if (we && size != 2 && !RMW) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(logic [31:0] word, int unsigned addr,
                                             int unsigned size, bit uns);
        longint v;
        int unsigned sh;
        if (size == 2) return word;
        sh = 8 * (addr % 4);
        v = longint'((word >> sh) & ((size == 0) ? 32'hFF : 32'hFFFF));
        if (!uns && size == 0 && v >= 128) v -= 256;
        if (!uns && size == 1 && v >= 32768) v -= 65536;
        return 32'(v);
    endfunction

    function automatic logic [31:0] ref_store(logic [31:0] old, int unsigned addr,
                                              int unsigned size, logic [31:0] wdata);
        longint unsigned mask, sh;
        if (size == 2) return wdata;
        sh = 8 * (addr % 4);
        mask = ((size == 0) ? 64'hFF : 64'hFFFF) << sh;
        return 32'(({32'h0, old} & ~mask) | (({32'h0, wdata} << sh) & mask));
    endfunction

    // Drives one request at the current (negedge) time and watches it to its response.
    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [TAG_W-1:0] tag);
        bit seen_en = 0;
        bit wseen = 0;
        logic [31:0] wd = 32'h0;
        ready_at_issue = req_ready;
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; req_tag = tag;
        @(posedge clk);
        r_lat = 0; rd_cyc = 0; wr_cyc = 0; both_cyc = 0; busy_ready = 0; unstable = 0;
        first_addr = 32'h0; r_data = 32'hX; r_err = 1'bX; r_tag = 'X;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = 1'b0;
            if (mem_read_enable) rd_cyc++;
            if (mem_write_enable) wr_cyc++;
            if (mem_read_enable && mem_write_enable) both_cyc++;
            if (mem_read_enable || mem_write_enable) begin
                if (!seen_en) begin seen_en = 1; first_addr = mem_addr; end
                else if (mem_addr !== first_addr) unstable = 1;
            end
            if (mem_write_enable) begin
                if (!wseen) begin wseen = 1; wd = mem_data_in; end
                else if (mem_data_in !== wd) unstable = 1;
            end
            if (resp_valid) begin
                r_lat = k; r_data = resp_data; r_err = resp_err; r_tag = resp_tag;
                break;
            end
            if (req_ready) busy_ready++;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; req_tag = '0;
        for (int i = 0; i < 16; i++) tbmem[i] = 32'h0;
        repeat (3) @(negedge clk);
        checks++; if (resp_valid !== 1'b0) begin
            $display("FAIL reset_resp_valid: got %b want 0", resp_valid); errors++; end
        checks++; if ({mem_read_enable, mem_write_enable} !== 2'b00) begin
            $display("FAIL reset_enables: got %b want 00", {mem_read_enable, mem_write_enable});
            errors++; end
        checks++; if (mem_addr !== 32'h0 || mem_data_in !== 32'h0) begin
            $display("FAIL reset_mem_bus: got %h/%h want 0/0", mem_addr, mem_data_in); errors++; end
        checks++; if (resp_data !== 32'h0 || resp_err !== 1'b0 || resp_tag !== '0) begin
            $display("FAIL reset_resp_fields: got %h/%b/%h want 0", resp_data, resp_err, resp_tag);
            errors++; end
        rstn = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin
            $display("FAIL reset_ready: got %b want 1", req_ready); errors++; end
    endtask

    task automatic test_load_word();
        tbmem[0] = 32'hDEAD_BEEF; miss_plan = 0;
        issue(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 5'd7);
        checks++; if (first_addr !== 32'h40) begin
            $display("FAIL ldw_mem_addr: got %h want 00000040", first_addr); errors++; end
        checks++; if (r_lat != 2) begin
            $display("FAIL ldw_latency: got %0d want 2", r_lat); errors++; end
        checks++; if (r_data !== 32'hDEAD_BEEF || r_err !== 1'b0) begin
            $display("FAIL ldw_data: got %h/%b want deadbeef/0", r_data, r_err); errors++; end
        checks++; if (r_tag !== 5'd7) begin
            $display("FAIL ldw_tag: got %0d want 7", r_tag); errors++; end
        checks++; if (rd_cyc != 1 || wr_cyc != 0 || busy_ready != 0) begin
            $display("FAIL ldw_enables: got rd %0d wr %0d busy_ready %0d want 1 0 0",
                     rd_cyc, wr_cyc, busy_ready); errors++; end
        @(negedge clk);
        checks++; if (resp_valid !== 1'b0) begin
            $display("FAIL ldw_pulse: got %b want 0", resp_valid); errors++; end
    endtask

    task automatic test_load_subword();
        tbmem[0] = 32'h80FF_FFFF; miss_plan = 0;
        issue(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 5'd1);
        checks++; if (r_data !== 32'hFFFF_FF80 || r_lat != 2) begin
            $display("FAIL ldb_signed: got %h lat %0d want ffffff80 lat 2", r_data, r_lat);
            errors++; end
        issue(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 5'd2);
        checks++; if (r_data !== 32'h0000_0080) begin
            $display("FAIL ldb_unsigned: got %h want 00000080", r_data); errors++; end
        issue(1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 5'd3);
        checks++; if (r_data !== 32'hFFFF_80FF) begin
            $display("FAIL ldh_signed: got %h want ffff80ff", r_data); errors++; end
    endtask

    task automatic test_store_word_miss();
        int unsigned wb = wr_cnt;
        miss_plan = 5;
        issue(1'b1, 2'd2, 1'b0, 32'h8, 32'h1234_5678, 5'd3);
        miss_plan = 0;
        checks++; if (wr_cyc != 6 || rd_cyc != 0 || unstable) begin
            $display("FAIL stw_hold: got wr %0d rd %0d unstable %0d want 6 0 0",
                     wr_cyc, rd_cyc, unstable); errors++; end
        checks++; if (first_addr !== 32'h2) begin
            $display("FAIL stw_addr: got %h want 00000002", first_addr); errors++; end
        checks++; if (r_lat != 7 || r_err !== 1'b0 || r_data !== 32'h0) begin
            $display("FAIL stw_resp: got lat %0d err %b data %h want 7 0 0", r_lat, r_err, r_data);
            errors++; end
        checks++; if (wr_cnt - wb != 1 || wr_data !== 32'h1234_5678) begin
            $display("FAIL stw_write: got %0d writes data %h want 1 12345678",
                     wr_cnt - wb, wr_data); errors++; end
        tbmem[2] = wr_data;
    endtask

    task automatic test_misaligned();
        logic [1:0]  sz [3];
        logic [31:0] ad [3];
        sz[0] = 2'd1; ad[0] = 32'h101;
        sz[1] = 2'd2; ad[1] = 32'h102;
        sz[2] = 2'd3; ad[2] = 32'h100;
        for (int i = 0; i < 3; i++) begin
            issue(1'b0, sz[i], 1'b0, ad[i], 32'h0, 5'(i + 20));
            checks++; if (r_lat != 1 || r_err !== 1'b1 || r_data !== 32'h0) begin
                $display("FAIL misalign_%0d_resp: got lat %0d err %b data %h want 1 1 0",
                         i, r_lat, r_err, r_data); errors++; end
            checks++; if (rd_cyc != 0 || wr_cyc != 0 || r_tag !== 5'(i + 20)) begin
                $display("FAIL misalign_%0d_mem: got rd %0d wr %0d tag %0d want 0 0 %0d",
                         i, rd_cyc, wr_cyc, r_tag, i + 20); errors++; end
        end
    endtask

    task automatic test_subword_store();
        int unsigned wb;
        tbmem[1] = 32'h1122_3344; miss_plan = 0; wb = wr_cnt;
        issue(1'b1, 2'd0, 1'b0, 32'h6, 32'h0000_00AA, 5'd4);
        if (wr_cnt != wb) tbmem[wr_addr[3:0]] = wr_data;
        checks++; if (r_lat != (RMW ? 3 : 1) || r_err !== !RMW) begin
            $display("FAIL stb_resp: got lat %0d err %b want %0d %b",
                     r_lat, r_err, RMW ? 3 : 1, !RMW); errors++; end
        checks++; if (tbmem[1] !== (RMW ? 32'h11AA_3344 : 32'h1122_3344)) begin
            $display("FAIL stb_memword: got %h want %h", tbmem[1],
                     RMW ? 32'h11AA_3344 : 32'h1122_3344); errors++; end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) tbmem[4 + i] = 32'h0101_0101 * (i + 1);
        miss_plan = 0;
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, 2'd2, 1'b0, 32'(16 + 4 * i), 32'h0, 5'(i));
            checks++; if (ready_at_issue !== 1'b1 || r_lat != 2) begin
                $display("FAIL b2b_%0d_timing: got ready %b lat %0d want 1 2",
                         i, ready_at_issue, r_lat); errors++; end
            checks++; if (r_data !== 32'h0101_0101 * (i + 1)) begin
                $display("FAIL b2b_%0d_data: got %h want %h", i, r_data, 32'h0101_0101 * (i + 1));
                errors++; end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin tbmem[i] = $urandom; ref_mem[i] = tbmem[i]; end
        for (int n = 0; n < 40; n++) begin
            logic we, uns, exp_err, rmw;
            logic [1:0] size;
            logic [31:0] addr, wdata, exp_data, exp_first;
            logic [TAG_W-1:0] tag;
            logic [3:0] idx;
            int unsigned miss, exp_lat, exp_rd, exp_wr, wb;
            we = 1'($urandom); uns = 1'($urandom); size = 2'($urandom_range(3));
            addr = $urandom_range(63); wdata = $urandom; tag = TAG_W'($urandom);
            miss = $urandom_range(3); idx = addr[5:2];
            exp_err = ref_err(we, size, addr);
            rmw = !exp_err && we && size != 2'd2;
            exp_data = (exp_err || we) ? 32'h0 : ref_load(ref_mem[idx], addr, size, uns);
            exp_first = exp_err ? 32'h0 : {2'b00, addr[31:2]};
            if (exp_err) begin exp_lat = 1; exp_rd = 0; exp_wr = 0; end
            else if (rmw) begin exp_lat = 2 * miss + 3; exp_rd = miss + 1; exp_wr = miss + 1; end
            else if (we) begin exp_lat = miss + 2; exp_rd = 0; exp_wr = miss + 1; end
            else begin exp_lat = miss + 2; exp_rd = miss + 1; exp_wr = 0; end
            if (!exp_err && we) ref_mem[idx] = ref_store(ref_mem[idx], addr, size, wdata);
            miss_plan = miss; wb = wr_cnt;
            issue(we, size, uns, addr, wdata, tag);
            if (wr_cnt != wb) tbmem[wr_addr[3:0]] = wr_data;
            checks++; if (r_lat != exp_lat || r_err !== exp_err) begin
                $display("FAIL rnd%0d_resp: got lat %0d err %b want %0d %b (we %b sz %0d a %h)",
                         n, r_lat, r_err, exp_lat, exp_err, we, size, addr); errors++; end
            checks++; if (r_data !== exp_data || r_tag !== tag) begin
                $display("FAIL rnd%0d_data: got %h tag %0d want %h tag %0d",
                         n, r_data, r_tag, exp_data, tag); errors++; end
            checks++; if (rd_cyc != exp_rd || wr_cyc != exp_wr || both_cyc != 0) begin
                $display("FAIL rnd%0d_enables: got rd %0d wr %0d both %0d want %0d %0d 0",
                         n, rd_cyc, wr_cyc, both_cyc, exp_rd, exp_wr); errors++; end
            checks++; if (unstable || busy_ready != 0 || first_addr !== exp_first) begin
                $display("FAIL rnd%0d_bus: got unstable %0d busy_ready %0d addr %h want 0 0 %h",
                         n, unstable, busy_ready, first_addr, exp_first); errors++; end
            checks++; if (wr_cnt - wb != ((exp_wr > 0) ? 1 : 0) || tbmem[idx] !== ref_mem[idx]) begin
                $display("FAIL rnd%0d_mem: got %0d writes word %h want %0d word %h",
                         n, wr_cnt - wb, tbmem[idx], (exp_wr > 0) ? 1 : 0, ref_mem[idx]);
                errors++; end
        end
        miss_plan = 0;
    endtask

    task automatic test_reset_mid_access();
        int unsigned wb = wr_cnt;
        int unsigned rv = 0;
        miss_plan = 20;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h8; req_wdata = 32'hCAFE_0001; req_tag = 5'd9;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        checks++; if (mem_write_enable !== 1'b1) begin
            $display("FAIL rstmid_started: got we %b want 1", mem_write_enable); errors++; end
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        checks++; if ({mem_read_enable, mem_write_enable} !== 2'b00) begin
            $display("FAIL rstmid_enables: got %b want 00", {mem_read_enable, mem_write_enable});
            errors++; end
        repeat (3) begin @(negedge clk); if (resp_valid) rv++; end
        rstn = 1'b1;
        miss_plan = 0;
        @(negedge clk);
        if (resp_valid) rv++;
        checks++; if (req_ready !== 1'b1 || mem_addr !== 32'h0) begin
            $display("FAIL rstmid_ready: got ready %b addr %h want 1 0", req_ready, mem_addr);
            errors++; end
        repeat (3) begin @(negedge clk); if (resp_valid) rv++; end
        checks++; if (rv != 0 || wr_cnt != wb) begin
            $display("FAIL rstmid_quiet: got %0d responses %0d writes want 0 0", rv, wr_cnt - wb);
            errors++; end
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_load_subword();
        test_store_word_miss();
        test_misaligned();
        test_subword_store();
        test_back_to_back();
        test_random();
        test_reset_mid_access();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store sequencer between the core's execute stage and the data-memory wrapper. It accepts one memory request per handshake, drives the wrapper's address/data/enable pins, holds them stable while the wrapper reports `miss`, and returns aligned, sign/zero-extended load data tagged with its destination register. Misaligned requests are rejected without touching memory.

## Interface
Parameters:
- `TAG_W`, 5: destination-register tag width.

Ports:
- `clk`  in  1  core clock; all state updates on rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request this cycle.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved (treated as misaligned).
- `req_unsigned`  in  1  loads: zero-extend instead of sign-extend.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-justified.
- `req_tag`  in  TAG_W  destination tag, echoed on response.
- `resp_valid`  out  1  one-cycle response pulse.
- `resp_data`  out  32  load result (0 for stores and errors).
- `resp_tag`  out  TAG_W  echoed tag.
- `resp_err`  out  1  misaligned/reserved request.
- `mem_addr`  out  32  word address `{2'b00, addr[31:2]}`.
- `mem_data_in`  out  32  write word.
- `mem_write_enable`  out  1.
- `mem_read_enable`  out  1.
- `mem_data_out`  in  32  read word, valid in the cycle `mem_miss` is low with read enabled.
- `mem_miss`  in  1  memory stall; access completes in any enabled cycle with `mem_miss` = 0.

## Operation
- States: IDLE, ACCESS, RESP; with `SUBWORD_RMW_EN` also RMW_RD, RMW_WR.
- IDLE/RESP: `req_ready` = 1. Handshake (`req_valid & req_ready`) latches addr, wdata, size, unsigned, tag, we.
- Alignment: word needs addr[1:0]=0, half needs addr[0]=0, size 3 always error. Error -> go to RESP directly, `resp_err`=1, no enable asserted.
- ACCESS: exactly one of `mem_read_enable`/`mem_write_enable` high; `mem_addr`, `mem_data_in` constant from entry until completion. Completion -> RESP.
- Loads: select byte lane addr[1:0] (little-endian), half lane addr[1]; extend per `req_unsigned`. Word loads pass through.
- Stores without macro: word stores only write directly; sub-word stores report `resp_err`=1.
- RESP: `resp_valid`=1 for one cycle; new request may be accepted same cycle (-> ACCESS or RESP), otherwise -> IDLE.
- Reset: all outputs 0 except `req_ready`=1 after release; async assertion mid-access drops both enables immediately, discards request, no response.

## Timing
- Accept at cycle 0; enable high cycles 1..n (n = first cycle with `mem_miss`=0); `resp_valid` at n+1. Zero-miss load: response cycle 2.
- Peak throughput: one request per 2 cycles.
- Error request: accepted cycle 0, `resp_valid` cycle 1.
- `resp_*` registered; `mem_*` registered from state (no combinational path from `req_*` to `mem_*`).

## Configuration
- `SUBWORD_RMW_EN` defined: sub-word stores do read-modify-write: RMW_RD (read, held through miss, word captured) -> RMW_WR (merged word written, held through miss) -> RESP. Zero-miss sub-word store response at cycle 3.
- Undefined: RMW states absent; sub-word stores error as above.

## Structure
- `mem_access_pkg`: size encodings, state enum, alignment-check function.
- Sub-module `mem_lane_align`: combinational load extract/extend and store byte-merge.

## Test plan
- Load word addr 0x100, `mem_miss`=0, `mem_data_out`=0xDEADBEEF, tag 7 -> `mem_addr`=0x40, `resp_valid` cycle 2, data 0xDEADBEEF, tag 7.
- Load byte signed addr 0x103, word 0x80FF_FF_FF -> resp 0xFFFFFF80; unsigned -> 0x00000080.
- Store word addr 0x8 data 0x12345678, `mem_miss` high 5 cycles -> enable and addr 0x2/data stable all 6 cycles, `resp_valid` cycle 7.
- Load half addr 0x101 -> `resp_err`=1 at cycle 1, enables never asserted.
- With `SUBWORD_RMW_EN`: store byte 0xAA to addr 0x6, memory word 0x11223344 -> write 0x11AA3344; without macro -> `resp_err`.
- Assert `rstn` low during held miss -> enables 0 immediately, no `resp_valid`; after release `req_ready`=1.
